// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Shares the single physical-memory port between the I-cache
//               and D-cache of the split-cache LC-3b datapath. One cache owns
//               the port at a time. Its address, command and write data are
//               muxed to memory, and pmem_resp is routed only to the owner.
//               Line read data is broadcast to both caches. Each cache
//               qualifies that data with its own resp.
// Ports       : clk, reset (async, active-high)
//               I-cache : i_pmem_read, i_pmem_address -> i_pmem_resp, i_pmem_rdata
//               D-cache : d_pmem_read, d_pmem_write, d_pmem_address,
//                         d_pmem_wdata -> d_pmem_resp, d_pmem_rdata
//               Memory  : pmem_read, pmem_write, pmem_address, pmem_wdata ->
//                         pmem_resp, pmem_rdata_in
// Options     : ARB_ROUND_ROBIN_EN selects the tie-break rule.
//               Defined   : the cache not served last wins a tie.
//               Undefined : fixed priority, and the D-cache wins every tie.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata_in,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    s_idle   = 2'd0,
    s_icache = 2'd1,
    s_dcache = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   i_req;
  logic   d_req;
  logic   d_wins_tie;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= s_idle;
    end else begin
      state <= next_state;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Records which cache completed a grant last. It is set to D on reset, so
  // the first tie goes to the I-cache. Aborted grants do not move it.
  logic last_served_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_served_d <= 1'b1;
    end else if (pmem_resp && (state == s_icache)) begin
      last_served_d <= 1'b0;
    end else if (pmem_resp && (state == s_dcache)) begin
      last_served_d <= 1'b1;
    end
  end

  assign d_wins_tie = ~last_served_d;
`else
  assign d_wins_tie = 1'b1;
`endif

  always_comb begin
    next_state   = state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    case (state)
      s_idle: begin
        // Granting here, rather than combinationally, puts the memory
        // command one cycle after the request.
        if (i_req && d_req) begin
          next_state = d_wins_tie ? s_dcache : s_icache;
        end else if (d_req) begin
          next_state = s_dcache;
        end else if (i_req) begin
          next_state = s_icache;
        end
      end
      s_icache: begin
        pmem_read    = i_pmem_read;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
        // A completion or a dropped request (abort) both return to idle.
        // This leaves a one-cycle bubble before the next grant.
        if (pmem_resp || !i_req) begin
          next_state = s_idle;
        end
      end
      s_dcache: begin
        pmem_write   = d_pmem_write;
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
        if (pmem_resp || !d_req) begin
          next_state = s_idle;
        end
      end
      default: begin
        next_state = s_idle;
      end
    endcase
  end

  assign i_pmem_rdata = pmem_rdata_in;
  assign d_pmem_rdata = pmem_rdata_in;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_arbiter
// Description : Scoreboard testbench for cache_arbiter. A stimulus process
//               drives cache agents and a memory responder, and pushes the
//               expected outputs of every cycle into a queue. A monitor pops
//               and compares those outputs on the falling edge. Define
//               ARB_ROUND_ROBIN_EN for the bench and the design together.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic         pread;
    logic         pwrite;
    logic         iresp;
    logic         dresp;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] irdata;
    logic [127:0] drdata;
  } obs_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic         d_pmem_resp;
  logic [127:0] pmem_rdata_in;
  logic [127:0] i_pmem_rdata;
  logic [127:0] d_pmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;

  cache_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write), .d_pmem_address(d_pmem_address),
    .d_pmem_wdata(d_pmem_wdata), .d_pmem_resp(d_pmem_resp),
    .pmem_rdata_in(pmem_rdata_in), .i_pmem_rdata(i_pmem_rdata), .d_pmem_rdata(d_pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // Reference model: owner 0 = nobody, 1 = I-cache, 2 = D-cache.
  int   owner;
  bit   last_d;
  int   cmd_cycles;
  bit   prev_presp;
  bit   d_persist;
  obs_t last_exp;
  obs_t exp_q[$];
  int   vectors;
  int   miscompares;

  localparam logic [127:0] WD1 = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] WD2 = 128'hCAFE_F00D_0123_4567_89AB_CDEF_0F0F_A5A5;

  function automatic string fmt(input obs_t o);
    return $sformatf("rd=%b wr=%b ir=%b dr=%b a=%h wd=%h ird=%h drd=%h",
                     o.pread, o.pwrite, o.iresp, o.dresp, o.addr, o.wdata, o.irdata, o.drdata);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address, pmem_wdata,
         i_pmem_rdata, d_pmem_rdata};
    return o;
  endfunction

  // What the port must show this cycle, given the current owner and inputs.
  function automatic obs_t expect_out();
    obs_t e;
    e        = '0;
    e.irdata = pmem_rdata_in;
    e.drdata = pmem_rdata_in;
    if (owner == 1) begin
      e.pread = i_pmem_read;
      e.addr  = i_pmem_address;
      e.iresp = pmem_resp;
    end else if (owner == 2) begin
      e.pwrite = d_pmem_write;
      e.pread  = d_pmem_read & ~d_pmem_write;
      e.addr   = d_pmem_address;
      e.wdata  = d_pmem_wdata;
      e.dresp  = pmem_resp;
    end
    return e;
  endfunction

  // Ownership update at a clock edge, from the inputs present at that edge.
  function automatic void model_step();
    bit ireq, dreq;
    ireq = i_pmem_read;
    dreq = d_pmem_read | d_pmem_write;
    if (reset) begin
      owner  = 0;
      last_d = 1'b1;
    end else if (owner == 0) begin
      if (ireq && dreq) owner = (RR && last_d) ? 1 : 2;
      else if (dreq)    owner = 2;
      else if (ireq)    owner = 1;
    end else if (owner == 1) begin
      if (pmem_resp) begin owner = 0; last_d = 1'b0; end
      else if (!ireq) owner = 0;
    end else begin
      if (pmem_resp) begin owner = 0; last_d = 1'b1; end
      else if (!dreq) owner = 0;
    end
  endfunction

  task automatic compare(input string name, input obs_t got, input obs_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s @%0t: got %s | want %s", name, $time, fmt(got), fmt(want));
    end
  endtask

  // pr_mode: 0 no resp, 1 force resp, 2 random memory, 3 fixed latency.
  task automatic step(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                      input logic [15:0] da, input logic [127:0] wd, input int pr_mode);
    obs_t e;
    bit   cmd;
    @(posedge clk);
    model_step();
    #1;
    reset          = 1'b0;
    i_pmem_read    = ir;
    i_pmem_address = ia;
    d_pmem_read    = dr;
    d_pmem_write   = dw;
    d_pmem_address = da;
    d_pmem_wdata   = wd;
    pmem_rdata_in  = {$urandom, $urandom, $urandom, $urandom};
    pmem_resp      = 1'b0;
    e              = expect_out();
    cmd            = e.pread | e.pwrite;
    cmd_cycles     = cmd ? cmd_cycles + 1 : 0;
    case (pr_mode)
      1: pmem_resp = 1'b1;
      2: pmem_resp = cmd ? ($urandom_range(0, 3) == 0)
                         : (!prev_presp && ($urandom_range(0, 19) == 0));
      3: pmem_resp = cmd && (cmd_cycles >= 3);
      default: pmem_resp = 1'b0;
    endcase
    prev_presp = pmem_resp;
    e          = expect_out();
    last_exp   = e;
    exp_q.push_back(e);
  endtask

  // Cache agents: hold a request until its own resp, then drop or re-request.
  task automatic tick(input bit rnd);
    logic        nir, ndr, ndw, start_d;
    logic [15:0] nia, nda;
    logic [127:0] nwd;
    int          r;
    nir = i_pmem_read;   nia = i_pmem_address;
    ndr = d_pmem_read;   ndw = d_pmem_write;
    nda = d_pmem_address; nwd = d_pmem_wdata;
    start_d = 1'b0;
    if (nir && last_exp.iresp) begin
      nir = rnd && ($urandom_range(0, 3) == 0);
      nia = 16'($urandom) & 16'hfff0;
    end else if (nir) begin
      if (rnd && ($urandom_range(0, 39) == 0)) nir = 1'b0;
    end else if (rnd && ($urandom_range(0, 2) == 0)) begin
      nir = 1'b1;
      nia = 16'($urandom) & 16'hfff0;
    end
    if ((ndr || ndw) && last_exp.dresp) begin
      start_d = d_persist || (rnd && ($urandom_range(0, 3) == 0));
      ndr = 1'b0; ndw = 1'b0;
    end else if (ndr || ndw) begin
      if (rnd && ($urandom_range(0, 39) == 0)) begin ndr = 1'b0; ndw = 1'b0; end
    end else if (rnd && ($urandom_range(0, 2) == 0)) begin
      start_d = 1'b1;
    end
    if (start_d) begin
      r   = $urandom_range(0, 7);
      ndw = (r < 4);
      ndr = (r >= 3);
      nda = 16'($urandom) & 16'hfff0;
      nwd = {$urandom, $urandom, $urandom, $urandom};
    end
    step(nir, nia, ndr, ndw, nda, nwd, rnd ? 2 : 3);
  endtask

  task automatic async_reset();
    obs_t e;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    owner    = 0;
    last_d   = 1'b1;
    e        = expect_out();
    last_exp = e;
    compare("async_reset", sample(), e);
  endtask

  // Monitor: one expected entry per cycle, checked on the falling edge.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("cycle", sample(), e);
      end
    end
  end

  initial begin
    reset = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata_in = '0; pmem_resp = 1'b0;
    owner = 0; last_d = 1'b1; cmd_cycles = 0; prev_presp = 1'b0; d_persist = 1'b0;
    last_exp = '0; vectors = 0; miscompares = 0;
    #2;
    compare("reset_state", sample(), expect_out());

    // I-cache read of 0x1230, response five cycles into the command.
    step(1'b1, 16'h1230, 1'b0, 1'b0, '0, '0, 0);
    repeat (4) step(1'b1, 16'h1230, 1'b0, 1'b0, '0, '0, 0);
    step(1'b1, 16'h1230, 1'b0, 1'b0, '0, '0, 1);
    step(1'b0, 16'h1230, 1'b0, 1'b0, '0, '0, 0);

    // D-cache write-back to 0x4000.
    repeat (3) step(1'b0, '0, 1'b0, 1'b1, 16'h4000, WD1, 0);
    step(1'b0, '0, 1'b0, 1'b1, 16'h4000, WD1, 1);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, '0, '0, 0);

    // Simultaneous I and D requests.
    step(1'b1, 16'h2220, 1'b1, 1'b0, 16'h3330, '0, 0);
    repeat (14) tick(1'b0);

    // D requests back to back while I waits.
    d_persist = 1'b1;
    step(1'b1, 16'h5550, 1'b1, 1'b0, 16'h6660, '0, 0);
    repeat (30) tick(1'b0);
    d_persist = 1'b0;
    repeat (14) tick(1'b0);

    // I-cache aborts, then a late response arrives while idle.
    repeat (3) step(1'b1, 16'h7770, 1'b0, 1'b0, '0, '0, 0);
    step(1'b0, 16'h7770, 1'b0, 1'b0, '0, '0, 0);
    step(1'b0, 16'h7770, 1'b0, 1'b0, '0, '0, 1);
    step(1'b0, 16'h7770, 1'b0, 1'b0, '0, '0, 0);

    // Reset in the middle of a D write-back, then a late response.
    repeat (3) step(1'b0, '0, 1'b0, 1'b1, 16'h8880, WD2, 0);
    async_reset();
    step(1'b0, '0, 1'b0, 1'b1, 16'h8880, WD2, 1);
    step(1'b0, '0, 1'b0, 1'b1, 16'h8880, WD2, 0);
    step(1'b0, '0, 1'b0, 1'b1, 16'h8880, WD2, 1);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, '0, '0, 0);

    // Randomized traffic.
    repeat (3000) tick(1'b1);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
